// File: rtl/ship_lives_ctl.sv
// Ship hit detection, life/respawn state machine and life-marker overlay.
// Video timing passes through with one register stage; markers are drawn over rgb_in.
module ship_lives_ctl #(
    parameter int          NUM_MISSILES  = 5,
    parameter int          MAX_LIVES     = 3,
    parameter int          SHIP_Y        = 680,
    parameter int          SHIP_W        = 64,
    parameter int          SHIP_H        = 48,
    parameter int          DEAD_FRAMES   = 60,
    parameter int          INVULN_FRAMES = 120,
    parameter int          HEART_X       = 20,
    parameter int          HEART_Y0      = 50,
    parameter int          HEART_PITCH   = 35,
    parameter int          HEART_SIZE    = 31,
    parameter logic [11:0] HEART_RGB     = 12'hF00
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [10:0]               ship_x,
    input  logic [11*NUM_MISSILES-1:0] en_x_missiles,
    input  logic [11*NUM_MISSILES-1:0] en_y_missiles,
    input  logic [10:0]               hcount_in,
    input  logic [10:0]               vcount_in,
    input  logic                      hsync_in,
    input  logic                      hblnk_in,
    input  logic                      vsync_in,
    input  logic                      vblnk_in,
    input  logic [11:0]               rgb_in,
    output logic [10:0]               hcount_out,
    output logic [10:0]               vcount_out,
    output logic                      hsync_out,
    output logic                      hblnk_out,
    output logic                      vsync_out,
    output logic                      vblnk_out,
    output logic [11:0]               rgb_out,
    output logic [3:0]                lives,
    output logic                      ship_down,
    output logic                      ship_hidden,
    output logic                      invuln,
    output logic                      game_over
);

    typedef enum logic [1:0] {ALIVE, DEAD, INVULN, OVER} state_t;

    localparam logic [11:0] SHIP_W12    = 12'(SHIP_W);
    localparam logic [11:0] SHIP_Y_LO   = 12'(SHIP_Y);
    localparam logic [11:0] SHIP_Y_HI   = 12'(SHIP_Y + SHIP_H - 1);
    localparam logic [11:0] HEART_X_LO  = 12'(HEART_X);
    localparam logic [11:0] HEART_X_HI  = 12'(HEART_X + HEART_SIZE - 1);
    localparam logic [11:0] HEART_S12   = 12'(HEART_SIZE);
    localparam logic [3:0]  LIVES_INIT  = 4'(MAX_LIVES);
    localparam logic [15:0] DEAD_LAST   = 16'(DEAD_FRAMES - 1);
    localparam logic [15:0] INVULN_LAST = 16'(INVULN_FRAMES - 1);

    state_t      state, state_d;
    logic [3:0]  lives_d;
    logic [15:0] cnt, cnt_d;
    logic        down_d;
    logic        vs_q, tick;
    logic        hit_any, hit_q;
    logic [11:0] mx, my, x_hi;
    logic [11:0] hc, vc, y_lo, y_hi;
    logic        marker_on, blink;
    logic [11:0] rgb_d;

    assign tick = vsync_in & ~vs_q;

    // Hit test in 12 bits so ship_x + SHIP_W near the right edge cannot wrap.
    always_comb begin
        hit_any = 1'b0;
        mx      = '0;
        my      = '0;
        x_hi    = {1'b0, ship_x} + SHIP_W12 - 12'd1;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            mx = {1'b0, en_x_missiles[11*i +: 11]};
            my = {1'b0, en_y_missiles[11*i +: 11]};
            if ((mx >= {1'b0, ship_x}) && (mx <= x_hi) &&
                (my >= SHIP_Y_LO) && (my <= SHIP_Y_HI))
                hit_any = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        lives_d = lives;
        cnt_d   = cnt;
        down_d  = 1'b0;
        case (state)
            ALIVE: begin
                // Leaving ALIVE on the first accepted hit makes held or multiple hits cost one life.
                if (hit_q) begin
                    down_d  = 1'b1;
                    lives_d = lives - 4'd1;
                    cnt_d   = '0;
                    state_d = (lives == 4'd1) ? OVER : DEAD;
                end
            end
            DEAD: begin
                if (DEAD_FRAMES == 0) begin
                    cnt_d   = '0;
                    state_d = INVULN;
                end else if (tick) begin
                    if (cnt == DEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = INVULN;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end
            INVULN: begin
                if (INVULN_FRAMES == 0) begin
                    cnt_d   = '0;
                    state_d = ALIVE;
                end else if (tick) begin
                    if (cnt == INVULN_LAST) begin
                        cnt_d   = '0;
                        state_d = ALIVE;
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end
            default: begin
                lives_d = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state       <= ALIVE;
            lives       <= LIVES_INIT;
            cnt         <= '0;
            hit_q       <= 1'b0;
            vs_q        <= 1'b0;
            ship_down   <= 1'b0;
            ship_hidden <= 1'b0;
            invuln      <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_d;
            lives       <= lives_d;
            cnt         <= cnt_d;
            hit_q       <= hit_any;
            vs_q        <= vsync_in;
            ship_down   <= down_d;
            ship_hidden <= (state_d == DEAD) || (state_d == OVER);
            invuln      <= (state_d == INVULN);
            game_over   <= (state_d == OVER);
        end
    end

    // Marker k sits at row HEART_Y0 + (k-1)*HEART_PITCH and is shown while k <= lives.
    always_comb begin
        hc        = {1'b0, hcount_in};
        vc        = {1'b0, vcount_in};
        marker_on = 1'b0;
        y_lo      = '0;
        y_hi      = '0;
        for (int k = 1; k <= MAX_LIVES; k++) begin
            y_lo = 12'(HEART_Y0 + (k - 1) * HEART_PITCH);
            y_hi = y_lo + HEART_S12 - 12'd1;
            if ((hc >= HEART_X_LO) && (hc <= HEART_X_HI) &&
                (vc >= y_lo) && (vc <= y_hi) && (4'(k) <= lives))
                marker_on = 1'b1;
        end
        blink = (state == INVULN) && cnt[3];
        if (hblnk_in || vblnk_in)
            rgb_d = 12'h000;
        else if (marker_on && !blink)
            rgb_d = HEART_RGB;
        else
            rgb_d = rgb_in;
    end

    // Overlay stage: all video outputs are the inputs delayed by one clock.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_d;
        end
    end

endmodule
